// File: rtl/branch_resolver_if.sv
// Branch resolver bus: fetch-side prediction handshake, execute-side
// resolution, and the flush/redirect/training/status outputs.
// The resolver connects through the slave modport; the pipeline side
// uses master.
interface branch_resolver_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned OW = $clog2(DEPTH) + 1;

  logic          pred_valid;
  logic          pred_ready;
  logic [31:0]   pred_pc;
  logic          pred_taken;
  logic [31:0]   pred_target;

  logic          ex_valid;
  logic [31:0]   ex_pc;
  logic          ex_taken;
  logic [31:0]   ex_target;

  logic          flush;
  logic [31:0]   redirect_pc;

  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic          upd_taken;
  logic          upd_mispredict;

  logic [OW-1:0] occupancy;
  logic          orphan_err;
  logic [31:0]   branch_count;
  logic [31:0]   mispredict_count;

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  ex_valid, ex_pc, ex_taken, ex_target,
    output pred_ready, flush, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_mispredict,
    output occupancy, orphan_err, branch_count, mispredict_count
  );

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output ex_valid, ex_pc, ex_taken, ex_target,
    input  pred_ready, flush, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, upd_mispredict,
    input  occupancy, orphan_err, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: queues fetch-stage predictions and checks each execute-
// stage resolution against the oldest one. A mispredict (or an orphan
// resolution with no matching head entry) empties the queue, issues a
// one-cycle flush with the corrected fetch PC, and spends one RECOVER cycle
// before accepting predictions again. Every accepted resolution also emits
// a one-cycle predictor training write.
// Optional: define BRANCH_RESOLVER_STATS_EN to enable the branch and
// mispredict counters; otherwise both counter outputs are tied to zero.
module branch_resolver #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  branch_resolver_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL, RECOVER} state_t;

  state_t        state;
  logic [31:0]   q_pc     [DEPTH];
  logic          q_taken  [DEPTH];
  logic [31:0]   q_target [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [OW-1:0] occ;

  logic          pred_ready_r;
  logic          flush_r;
  logic [31:0]   redirect_r;
  logic          upd_valid_r;
  logic [31:0]   upd_pc_r;
  logic          upd_taken_r;
  logic          upd_mis_r;
  logic          orphan_r;

  logic          resolve;
  logic          push;
  logic          pop;
  logic          orphan;
  logic          mispredict;
  logic [31:0]   redirect_next;
  logic [OW-1:0] occ_next;

  // Resolution decision against the head entry and next fill level.
  always_comb begin
    resolve       = bus.ex_valid && (state != RECOVER);
    push          = bus.pred_valid && pred_ready_r;
    orphan        = (occ == '0) || (bus.ex_pc != q_pc[rd_ptr]);
    mispredict    = orphan
                  || (bus.ex_taken != q_taken[rd_ptr])
                  || (bus.ex_taken && (bus.ex_target != q_target[rd_ptr]));
    redirect_next = bus.ex_taken ? bus.ex_target : (bus.ex_pc + 32'd4);
    pop           = resolve && !mispredict;
    occ_next      = occ + OW'(push) - OW'(pop);
  end

  // Queue storage; a same-cycle enqueue is dropped when the queue is flushed.
  always_ff @(posedge clk) begin
    if (push && !(resolve && mispredict)) begin
      q_pc[wr_ptr]     <= bus.pred_pc;
      q_taken[wr_ptr]  <= bus.pred_taken;
      q_target[wr_ptr] <= bus.pred_target;
    end
  end

  // FSM, pointers, fill level and all registered outputs.
  // pred_ready is registered from the next fill level/state so that it never
  // depends combinationally on ex_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      occ          <= '0;
      pred_ready_r <= 1'b0;
      flush_r      <= 1'b0;
      redirect_r   <= '0;
      upd_valid_r  <= 1'b0;
      upd_pc_r     <= '0;
      upd_taken_r  <= 1'b0;
      upd_mis_r    <= 1'b0;
      orphan_r     <= 1'b0;
    end else begin
      upd_valid_r <= resolve;
      flush_r     <= resolve && mispredict;
      if (resolve) begin
        upd_pc_r    <= bus.ex_pc;
        upd_taken_r <= bus.ex_taken;
        upd_mis_r   <= mispredict;
        if (orphan) orphan_r <= 1'b1;
      end

      if (resolve && mispredict) begin
        redirect_r   <= redirect_next;
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        occ          <= '0;
        state        <= RECOVER;
        pred_ready_r <= 1'b0;
      end else if (state == RECOVER) begin
        state        <= EMPTY;
        pred_ready_r <= 1'b1;
      end else begin
        rd_ptr       <= rd_ptr + PW'(pop);
        wr_ptr       <= wr_ptr + PW'(push);
        occ          <= occ_next;
        pred_ready_r <= (occ_next != OW'(DEPTH));
        if (occ_next == '0)
          state <= EMPTY;
        else if (occ_next == OW'(DEPTH))
          state <= FULL;
        else
          state <= PARTIAL;
      end
    end
  end

  assign bus.pred_ready     = pred_ready_r;
  assign bus.flush          = flush_r;
  assign bus.redirect_pc    = redirect_r;
  assign bus.upd_valid      = upd_valid_r;
  assign bus.upd_pc         = upd_pc_r;
  assign bus.upd_taken      = upd_taken_r;
  assign bus.upd_mispredict = upd_mis_r;
  assign bus.occupancy      = occ;
  assign bus.orphan_err     = orphan_r;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] mis_cnt;

  // Statistics counters follow the training write pulses, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt <= '0;
      mis_cnt    <= '0;
    end else if (upd_valid_r) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (upd_mis_r) mis_cnt <= mis_cnt + 32'd1;
    end
  end

  assign bus.branch_count     = branch_cnt;
  assign bus.mispredict_count = mis_cnt;
`else
  assign bus.branch_count     = '0;
  assign bus.mispredict_count = '0;
`endif
endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the number of in-flight prediction queue entries (power of two, at least 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port pred_valid, input, 1 bit: the fetch stage offers a prediction.
REQ-005 The block SHALL have port pred_ready, output, 1 bit: the queue accepts a prediction.
REQ-006 The block SHALL have ports pred_pc (input, 32 bits, branch PC), pred_taken (input, 1 bit, predicted direction) and pred_target (input, 32 bits, predicted next PC).
REQ-007 The block SHALL have port ex_valid, input, 1 bit: the execute stage resolves a branch this cycle.
REQ-008 The block SHALL have ports ex_pc (input, 32 bits), ex_taken (input, 1 bit, actual outcome) and ex_target (input, 32 bits, computed taken target).
REQ-009 The block SHALL have ports flush (output, 1 bit, pipeline flush pulse) and redirect_pc (output, 32 bits, corrected fetch PC).
REQ-010 The block SHALL have ports upd_valid (output, 1 bit), upd_pc (output, 32 bits), upd_taken (output, 1 bit) and upd_mispredict (output, 1 bit): the predictor-table training write.
REQ-011 The block SHALL have ports occupancy (output, log2(DEPTH)+1 bits, queue fill level) and orphan_err (output, 1 bit, sticky error flag).
REQ-012 The block SHALL have ports branch_count and mispredict_count, both output, 32 bits (see Configuration).

Function
REQ-013 The block SHALL hold predictions in a FIFO of DEPTH entries {pc, taken, target}; an entry is enqueued on a rising edge when pred_valid and pred_ready are both 1.
REQ-014 pred_ready SHALL equal not-full and not-RECOVER; it SHALL NOT depend combinationally on ex_valid, so a full queue refuses input even in a cycle that pops.
REQ-015 The FSM SHALL have states EMPTY, PARTIAL, FULL and RECOVER, with EMPTY/PARTIAL/FULL set by occupancy after each edge.
REQ-016 In EMPTY, PARTIAL or FULL, an ex_valid cycle SHALL compare the resolution against the head entry.
REQ-017 The resolution SHALL count as a mispredict when ex_taken differs from head.taken, or when ex_taken=1 and ex_target differs from head.target.
REQ-018 A correct resolution SHALL pop the head; an enqueue in the same cycle is allowed, leaving occupancy unchanged.
REQ-019 A mispredict SHALL clear all entries, drop any same-cycle enqueue and move the FSM to RECOVER.
REQ-020 The redirect address SHALL be ex_target when ex_taken=1, else ex_pc+4 with 32-bit wrap (0xFFFFFFFC -> 0x00000000).
REQ-021 flush and redirect_pc SHALL be registered: flush pulses high for exactly one cycle, the cycle after the mispredicting ex_valid.
REQ-022 RECOVER SHALL last exactly one cycle, ignore ex_valid, hold pred_ready=0, and then go to EMPTY.
REQ-023 Every ex_valid accepted outside RECOVER SHALL produce, one cycle later, a one-cycle upd_valid pulse with upd_pc=ex_pc, upd_taken=ex_taken and upd_mispredict equal to the mispredict decision.
REQ-024 An ex_valid when the queue is empty, or when ex_pc differs from head.pc, SHALL be treated as a mispredict and SHALL set orphan_err, which stays set until reset.
REQ-025 redirect_pc SHALL hold its last value while flush=0.

Reset
REQ-026 While rst=1, the block SHALL asynchronously force: FSM=EMPTY, occupancy=0, queue pointers=0, flush=0, upd_valid=0, upd_mispredict=0, upd_taken=0, upd_pc=0, redirect_pc=0, orphan_err=0, both counters=0, pred_ready=0.
REQ-027 pred_ready SHALL return to 1 on the first edge after rst falls; a reset mid-RECOVER SHALL abort the flush pulse.

Configuration
REQ-028 With macro BRANCH_RESOLVER_STATS_EN defined, branch_count SHALL increment on each upd_valid and mispredict_count on each upd_valid with upd_mispredict=1, both wrapping at 2^32.
REQ-029 Without BRANCH_RESOLVER_STATS_EN, both counter ports SHALL be driven constant 0 and no counter registers SHALL exist.

Verification
REQ-030 The bench SHALL cover: enqueue {pc=0x100, taken=1, target=0x140}; ex_valid with ex_pc=0x100, ex_taken=1, ex_target=0x140 -> upd_valid=1 with upd_mispredict=0, flush=0, occupancy 1->0.
REQ-031 The bench SHALL cover: enqueue three entries, head {0x200, taken=0}; resolve with ex_taken=1, ex_target=0x180 -> next cycle flush=1 and redirect_pc=0x180, occupancy=0, one RECOVER cycle with pred_ready=0.
REQ-032 The bench SHALL cover: head {0x300, taken=1, target=0x340}; resolve with ex_taken=0 -> redirect_pc=0x304 and upd_mispredict=1.
REQ-033 The bench SHALL cover: fill DEPTH entries -> pred_ready=0; a correct pop with pred_valid=1 in the same cycle -> no enqueue, occupancy=DEPTH-1.
REQ-034 The bench SHALL cover: ex_valid with the queue empty, ex_pc=0xFFFFFFFC, ex_taken=0 -> flush=1, redirect_pc=0x00000000, orphan_err=1 held.
REQ-035 The bench SHALL cover: with STATS_EN, run 5 resolutions including 2 mispredicts -> branch_count=5 and mispredict_count=2; assert rst mid-run -> all outputs 0 immediately.
